// File: rtl/conv1d_mul_driver_if.sv
// Channel bundle for the conv1d multiplier sequencer: filter/ifmap load inputs,
// the operand/product pair to the PE multiplier, and the psum output with its done pulse.
interface conv1d_mul_driver_if #(
  parameter int WIDTH     = 8,
  parameter int FILT_LEN  = 3,
  parameter int IFMAP_LEN = 5
);
  localparam int ACC_W = 2*WIDTH + $clog2(FILT_LEN);
  localparam int IDX_W = $clog2(IFMAP_LEN);

  logic               w_valid;
  logic               w_ready;
  logic [WIDTH-1:0]   w_data;
  logic               i_valid;
  logic               i_ready;
  logic [WIDTH-1:0]   i_data;
  logic               mul_valid;
  logic               mul_ready;
  logic [WIDTH-1:0]   mul_a;
  logic [WIDTH-1:0]   mul_b;
  logic               prod_valid;
  logic               prod_ready;
  logic [2*WIDTH-1:0] prod_data;
  logic               out_valid;
  logic               out_ready;
  logic [ACC_W-1:0]   out_data;
  logic [IDX_W-1:0]   out_idx;
  logic               done;

  modport master (
    input  w_valid, w_data, i_valid, i_data, mul_ready, prod_valid, prod_data, out_ready,
    output w_ready, i_ready, mul_valid, mul_a, mul_b, prod_ready, out_valid, out_data, out_idx, done
  );

  modport slave (
    output w_valid, w_data, i_valid, i_data, mul_ready, prod_valid, prod_data, out_ready,
    input  w_ready, i_ready, mul_valid, mul_a, mul_b, prod_ready, out_valid, out_data, out_idx, done
  );
endinterface

// File: rtl/conv1d_mul_driver.sv
// Buffers one filter and one ifmap row, then walks every 1-D conv output position,
// feeding one operand pair at a time to the multiplier and accumulating the returned products.
module conv1d_mul_driver #(
  parameter int WIDTH     = 8,
  parameter int FILT_LEN  = 3,
  parameter int IFMAP_LEN = 5
) (
  input  logic clk,
  input  logic rst_n,
  conv1d_mul_driver_if.master bus
);
  localparam int ACC_W = 2*WIDTH + $clog2(FILT_LEN);
  localparam int KW    = $clog2(FILT_LEN);
  localparam int IW    = $clog2(IFMAP_LEN);

  localparam logic [KW-1:0] K_LAST = KW'(FILT_LEN-1);
  localparam logic [IW-1:0] W_LAST = IW'(FILT_LEN-1);
  localparam logic [IW-1:0] I_LAST = IW'(IFMAP_LEN-1);
  localparam logic [IW-1:0] O_LAST = IW'(IFMAP_LEN-FILT_LEN);

  typedef enum logic [2:0] {LOAD_W, LOAD_I, ISSUE, WAIT_P, EMIT} state_e;

  logic [WIDTH-1:0] wbuf_q [FILT_LEN];
  logic [WIDTH-1:0] ibuf_q [IFMAP_LEN];

  state_e           state_q, state_d;
  logic [IW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    o_q, o_d;
  logic [KW-1:0]    k_q, k_d;
  logic [ACC_W-1:0] acc_q, acc_d, acc_sum;

  logic             w_ready_q, w_ready_d;
  logic             i_ready_q, i_ready_d;
  logic             mul_valid_q, mul_valid_d;
  logic [WIDTH-1:0] mul_a_q, mul_a_d;
  logic [WIDTH-1:0] mul_b_q, mul_b_d;
  logic             prod_ready_q, prod_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] out_data_q, out_data_d;
  logic [IW-1:0]    out_idx_q, out_idx_d;
  logic             done_q, done_d;

  logic             w_we, i_we, load_ops;
  logic [KW-1:0]    nk;
  logic [IW-1:0]    pos;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    o_d          = o_q;
    k_d          = k_q;
    acc_d        = acc_q;
    w_ready_d    = w_ready_q;
    i_ready_d    = i_ready_q;
    mul_valid_d  = mul_valid_q;
    prod_ready_d = prod_ready_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_idx_d    = out_idx_q;
    done_d       = 1'b0;
    w_we         = 1'b0;
    i_we         = 1'b0;
    load_ops     = 1'b0;
    nk           = '0;
    pos          = '0;
    acc_sum      = acc_q + ACC_W'(bus.prod_data);

    unique case (state_q)
      LOAD_W: if (bus.w_valid && w_ready_q) begin
        w_we = 1'b1;
        if (cnt_q == W_LAST) begin
          cnt_d     = '0;
          w_ready_d = 1'b0;
          i_ready_d = 1'b1;
          state_d   = LOAD_I;
        end else begin
          cnt_d = cnt_q + IW'(1);
        end
      end
      // ibuf[0] is already written when the last ifmap value lands, so the first pair can be staged now
      LOAD_I: if (bus.i_valid && i_ready_q) begin
        i_we = 1'b1;
        if (cnt_q == I_LAST) begin
          cnt_d       = '0;
          i_ready_d   = 1'b0;
          k_d         = '0;
          o_d         = '0;
          acc_d       = '0;
          mul_valid_d = 1'b1;
          load_ops    = 1'b1;
          state_d     = ISSUE;
        end else begin
          cnt_d = cnt_q + IW'(1);
        end
      end
      ISSUE: if (bus.mul_ready && mul_valid_q) begin
        mul_valid_d  = 1'b0;
        prod_ready_d = 1'b1;
        state_d      = WAIT_P;
      end
      WAIT_P: if (bus.prod_valid && prod_ready_q) begin
        acc_d        = acc_sum;
        prod_ready_d = 1'b0;
        if (k_q == K_LAST) begin
          out_valid_d = 1'b1;
          out_data_d  = acc_sum;
          out_idx_d   = o_q;
          state_d     = EMIT;
        end else begin
          k_d         = k_q + KW'(1);
          nk          = k_q + KW'(1);
          pos         = o_q + IW'(k_q) + IW'(1);
          load_ops    = 1'b1;
          mul_valid_d = 1'b1;
          state_d     = ISSUE;
        end
      end
      EMIT: if (bus.out_ready && out_valid_q) begin
        out_valid_d = 1'b0;
        acc_d       = '0;
        k_d         = '0;
        if (o_q == O_LAST) begin
          done_d    = 1'b1;
          w_ready_d = 1'b1;
          o_d       = '0;
          state_d   = LOAD_W;
        end else begin
          o_d         = o_q + IW'(1);
          pos         = o_q + IW'(1);
          load_ops    = 1'b1;
          mul_valid_d = 1'b1;
          state_d     = ISSUE;
        end
      end
      default: state_d = LOAD_W;
    endcase

    mul_a_d = load_ops ? wbuf_q[nk]  : mul_a_q;
    mul_b_d = load_ops ? ibuf_q[pos] : mul_b_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= LOAD_W;
      cnt_q        <= '0;
      o_q          <= '0;
      k_q          <= '0;
      acc_q        <= '0;
      w_ready_q    <= 1'b1;
      i_ready_q    <= 1'b0;
      mul_valid_q  <= 1'b0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      prod_ready_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_idx_q    <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      o_q          <= o_d;
      k_q          <= k_d;
      acc_q        <= acc_d;
      w_ready_q    <= w_ready_d;
      i_ready_q    <= i_ready_d;
      mul_valid_q  <= mul_valid_d;
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      prod_ready_q <= prod_ready_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_idx_q    <= out_idx_d;
      done_q       <= done_d;
    end
  end

  // Row buffers keep their contents across reset; they are always fully rewritten before use.
  always_ff @(posedge clk) begin
    if (w_we) wbuf_q[cnt_q[KW-1:0]] <= bus.w_data;
    if (i_we) ibuf_q[cnt_q]         <= bus.i_data;
  end

  assign bus.w_ready    = w_ready_q;
  assign bus.i_ready    = i_ready_q;
  assign bus.mul_valid  = mul_valid_q;
  assign bus.mul_a      = mul_a_q;
  assign bus.mul_b      = mul_b_q;
  assign bus.prod_ready = prod_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_idx    = out_idx_q;
  assign bus.done       = done_q;
endmodule

// File: tb/tb_conv1d_mul_driver.sv
// Randomized bench for conv1d_mul_driver: row loader, multiplier and psum sink models
// driven each negedge, with psums and operand order predicted from plain convolution sums.
module tb_conv1d_mul_driver;
  localparam int WIDTH = 8;
  localparam int FL    = 3;
  localparam int IL    = 5;
  localparam int NO    = IL - FL + 1;
  localparam int IW    = $clog2(IL);
  localparam int PW    = 2*WIDTH;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  conv1d_mul_driver_if #(.WIDTH(WIDTH), .FILT_LEN(FL), .IFMAP_LEN(IL)) bus ();
  conv1d_mul_driver #(.WIDTH(WIDTH), .FILT_LEN(FL), .IFMAP_LEN(IL)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  int          w [FL];
  int          im [IL];
  longint      exp_ps [NO];
  int          qa [$];
  int          qb [$];
  bit          pend, done_exp, row_fin, rnd, spur, hold_v;
  longint      pval;
  int          pdly, pdly_fix, wi, ii, nout, stall_idx, stall_left;
  logic [63:0] hold_val;

  // Expected psums and pair order straight from the convolution definition.
  task automatic setup_row();
    qa.delete();
    qb.delete();
    for (int o = 0; o < NO; o++) begin
      exp_ps[o] = 0;
      for (int k = 0; k < FL; k++) begin
        exp_ps[o] += longint'(w[k]) * longint'(im[o+k]);
        qa.push_back(w[k]);
        qb.push_back(im[o+k]);
      end
    end
    wi = 0; ii = 0; nout = 0; row_fin = 0;
  endtask

  task automatic step();
    bit ofire;
    @(negedge clk);
    if (done_exp || bus.done) begin
      chk("done", bus.done, done_exp);
      row_fin = done_exp;
    end
    done_exp = 0;

    bus.prod_valid = 1'b0;
    bus.prod_data  = '0;
    if (pend) begin
      if (pdly > 0) pdly--;
      else begin
        bus.prod_valid = 1'b1;
        bus.prod_data  = PW'(pval);
        if (bus.prod_ready) pend = 0;
      end
    end else if (spur && $urandom_range(0, 2) == 0) begin
      bus.prod_valid = 1'b1;
      bus.prod_data  = PW'($urandom);
      chk("spur_prod_ready", bus.prod_ready, 0);
    end

    bus.mul_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
    if (bus.mul_valid && bus.mul_ready) begin
      chk("one_outstanding", pend, 0);
      chk("pair_avail", qa.size() > 0, 1);
      if (qa.size() > 0) begin
        chk("mul_a", bus.mul_a, qa.pop_front());
        chk("mul_b", bus.mul_b, qb.pop_front());
      end
      pend = 1;
      pval = longint'(bus.mul_a) * longint'(bus.mul_b);
      pdly = rnd ? $urandom_range(0, 3) : pdly_fix;
    end

    if (stall_left > 0 && bus.out_valid && bus.out_idx == IW'(stall_idx)) begin
      bus.out_ready = 1'b0;
      stall_left--;
      chk("stall_mul_idle", bus.mul_valid, 0);
    end else begin
      bus.out_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
    if (hold_v) chk("out_hold", {bus.out_valid, bus.out_idx, bus.out_data}, hold_val);
    ofire    = bus.out_valid && bus.out_ready;
    hold_v   = bus.out_valid && !bus.out_ready;
    hold_val = {bus.out_valid, bus.out_idx, bus.out_data};
    if (ofire) begin
      chk("psum_avail", nout < NO, 1);
      if (nout < NO) begin
        chk("psum", bus.out_data, exp_ps[nout]);
        chk("out_idx", bus.out_idx, nout);
      end
      nout++;
      if (nout == NO) done_exp = 1;
    end

    if (wi < FL) begin
      bus.w_valid = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      bus.w_data  = WIDTH'(w[wi]);
    end else if (nout < NO) begin
      bus.w_valid = 1'b1;
      bus.w_data  = WIDTH'($urandom);
      chk("w_ready_idle", bus.w_ready, 0);
    end else bus.w_valid = 1'b0;
    if (bus.w_valid && bus.w_ready && wi < FL) wi++;

    if (wi == FL && ii < IL) begin
      bus.i_valid = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      bus.i_data  = WIDTH'(im[ii]);
      if (bus.i_valid && bus.i_ready) ii++;
    end else if (nout < NO) begin
      bus.i_valid = 1'b1;
      bus.i_data  = WIDTH'($urandom);
      chk("i_ready_idle", bus.i_ready, 0);
    end else bus.i_valid = 1'b0;
  endtask

  task automatic run_row();
    int cyc = 0;
    setup_row();
    while (!row_fin && cyc < 3000) begin
      step();
      cyc++;
    end
    chk("row_finished", row_fin, 1);
    chk("pairs_left", qa.size(), 0);
  endtask

  task automatic check_rst(input string tag);
    chk({tag, "_valids"}, {bus.mul_valid, bus.out_valid, bus.prod_ready, bus.i_ready, bus.done}, 0);
    chk({tag, "_w_ready"}, bus.w_ready, 1);
    chk({tag, "_mul_ops"}, {bus.mul_a, bus.mul_b}, 0);
    chk({tag, "_out"}, {bus.out_data, bus.out_idx}, 0);
  endtask

  task automatic quiet_inputs();
    bus.w_valid = 0; bus.w_data = '0; bus.i_valid = 0; bus.i_data = '0;
    bus.mul_ready = 0; bus.prod_valid = 0; bus.prod_data = '0; bus.out_ready = 0;
  endtask

  task automatic case1_data();
    for (int k = 0; k < FL; k++) w[k] = k + 1;
    for (int i = 0; i < IL; i++) im[i] = i + 1;
  endtask

  initial begin
    int cyc;
    quiet_inputs();
    pend = 0; done_exp = 0; hold_v = 0; rnd = 0; spur = 0;
    pdly_fix = 0; stall_idx = 0; stall_left = 0;
    repeat (3) @(negedge clk);
    check_rst("reset");
    rst_n = 1'b1;

    case1_data();
    run_row();

    stall_idx = 1; stall_left = 10;
    run_row();
    chk("stall_used", stall_left, 0);

    rnd = 1; spur = 1;
    for (int k = 0; k < FL; k++) w[k] = 255;
    for (int i = 0; i < IL; i++) im[i] = 255;
    run_row();

    // Reset while the multiplier holds the second output's first product.
    rnd = 0; spur = 0; pdly_fix = 5;
    case1_data();
    setup_row();
    cyc = 0;
    while (!(pend && nout == 1 && bus.prod_ready) && cyc < 500) begin
      step();
      cyc++;
    end
    chk("reached_wait_p", pend && nout == 1 && bus.prod_ready, 1);
    #2 rst_n = 1'b0;
    #1 check_rst("async_rst");
    quiet_inputs();
    pend = 0; hold_v = 0; done_exp = 0; pdly_fix = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_row();

    rnd = 1; spur = 1;
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < FL; k++) w[k] = int'($urandom_range(0, 255));
      for (int i = 0; i < IL; i++) im[i] = int'($urandom_range(0, 255));
      run_row();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end
endmodule
